// File: rtl/sram_like_data_responder_pkg.sv
// sram_like_data_responder_pkg: shared size encodings and response-entry layout
package sram_like_data_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } resp_t;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sram_like_data_responder_resp_fifo.sv
// sram_like_data_responder_resp_fifo: in-order response queue with per-entry delay countdown
module sram_like_data_responder_resp_fifo
    import sram_like_data_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  resp_t             push_ent,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_ready,
    output logic              empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    resp_t         ent_q [DEPTH];
    resp_t         ent_d [DEPTH];

    // Age every entry, drop the head on pop, then append behind the survivors on push
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i]     = ent_q[i];
            ent_d[i].cnt = sat_dec(ent_q[i].cnt);
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_d[i + 1];
            cnt_d = cnt_d - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) if (i == int'(cnt_d)) ent_d[i] = push_ent;
            cnt_d = cnt_d + CW'(1);
        end
    end

    assign head_data  = ent_q[0].data;
    assign empty      = (cnt_q == '0);
    assign head_ready = !empty && (ent_q[0].cnt == '0);

    // Queue storage and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ent_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end

    // The outstanding limit upstream must keep the queue from overflowing
    assert property (@(posedge clk) disable iff (reset) !(push && !pop && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/sram_like_data_responder.sv
// sram_like_data_responder: slave end of the sram-like req/addr_ok/data_ok data interface
module sram_like_data_responder
    import sram_like_data_responder_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int MAX_OUTST  = 2,
    parameter int ADDR_DELAY = 0,
    parameter int DATA_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int OW = 3;

    logic [OW-1:0]     outst_q, outst_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              s_valid_q, s_valid_d;
    logic              s_wr_q, s_wr_d;
    logic [CNT_W-1:0]  s_cnt_q, s_cnt_d;
    logic              hs, bypass, push, empty, head_ready;
    logic [DATA_W-1:0] s_data, head_data;
    resp_t             push_ent;
    logic              unused_ok;

    // Accept only when a slot is free and req has been held long enough; no path from data_ok
    assign addr_ok   = req && !reset && (outst_q < OW'(MAX_OUTST)) && (wait_q == CNT_W'(ADDR_DELAY));
    assign hs        = addr_ok;

    assign ram_en    = hs;
    assign ram_we    = (hs && wr) ? wstrb : 4'b0;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    // The stage register holds the request during the RAM read cycle
    assign s_data    = s_wr_q ? '0 : ram_rdata;
    assign bypass    = s_valid_q && empty && (s_cnt_q == '0);
    assign push      = s_valid_q && !bypass;
    assign push_ent  = '{wr: s_wr_q, data: s_data, cnt: sat_dec(s_cnt_q)};

    assign data_ok   = !reset && (bypass || head_ready);
    assign rdata     = !data_ok ? '0 : bypass ? s_data : head_data;

    assign unused_ok = ^{size, addr[31:RAM_AW+2], addr[1:0]};

    sram_like_data_responder_resp_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_ent  (push_ent),
        .pop       (head_ready),
        .head_data (head_data),
        .head_ready(head_ready),
        .empty     (empty)
    );

    // Next-state: address-phase wait, stage register load, outstanding count
    always_comb begin
        wait_d    = (!req || hs) ? '0 : (wait_q == CNT_W'(ADDR_DELAY)) ? wait_q : wait_q + CNT_W'(1);
        s_valid_d = hs;
        s_wr_d    = wr;
        s_cnt_d   = CNT_W'(DATA_DELAY);
        outst_d   = (hs && !data_ok) ? outst_q + OW'(1) : (!hs && data_ok) ? outst_q - OW'(1) : outst_q;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q   <= '0;
            wait_q    <= '0;
            s_valid_q <= 1'b0;
            s_wr_q    <= 1'b0;
            s_cnt_q   <= '0;
        end else begin
            outst_q   <= outst_d;
            wait_q    <= wait_d;
            s_valid_q <= s_valid_d;
            s_wr_q    <= s_wr_d;
            s_cnt_q   <= s_cnt_d;
        end
    end

    assert property (@(posedge clk) disable iff (reset) outst_q <= OW'(MAX_OUTST));

endmodule
